riot_timer_ctrl: RTL

Bus-side controller for the 6532-style interval timer. It decodes CPU accesses into timer load strobes (WE/MODE/IN) and reads back the timer count. It owns the timer-underflow and PA7-edge interrupt flags, their enables and IRQ_N generation. It sits between the CPU bus decode and the interval timer instance inside the mm6532 wrapper.

---
 rtl/riot_timer_ctrl_pkg.sv | 25 ++
 rtl/riot_timer_ctrl_if.sv | 12 +
 rtl/riot_edge_det.sv | 30 +++
 rtl/riot_timer_ctrl.sv | 81 ++++++++
 4 files changed

// File: rtl/riot_timer_ctrl_pkg.sv
// Shared constants for the 6532-style timer controller: prescale modes,
// address-bit decode positions and flag-byte layout.
package riot_timer_ctrl_pkg;
  localparam logic [1:0] C_TIM_0001T = 2'b00;
  localparam logic [1:0] C_TIM_0008T = 2'b01;
  localparam logic [1:0] C_TIM_0064T = 2'b10;
  localparam logic [1:0] C_TIM_1024T = 2'b11;

  localparam int A_TIMER_SEL = 4;
  localparam int A_IRQ_EN    = 3;
  localparam int A_FLAG_SEL  = 0;
  localparam int A_PIE       = 1;
  localparam int A_POL       = 0;

  localparam int F_TF = 7;
  localparam int F_PF = 6;

  function automatic logic [7:0] flag_byte(input logic tf, input logic pf);
    logic [7:0] b;
    b       = '0;
    b[F_TF] = tf;
    b[F_PF] = pf;
    return b;
  endfunction
endpackage

// File: rtl/riot_timer_ctrl_if.sv
// CPU-side bus of the timer controller: access strobes, read data and IRQ.
interface riot_timer_ctrl_if;
  logic       CS;
  logic       RW;
  logic [4:0] A;
  logic [7:0] DIN;
  logic [7:0] DOUT;
  logic       IRQ_N;

  modport master (output CS, RW, A, DIN, input DOUT, IRQ_N);
  modport slave  (input CS, RW, A, DIN, output DOUT, IRQ_N);
endinterface

// File: rtl/riot_edge_det.sv
// PA7 synchronizer and polarity-selectable edge detector; match is a
// one-cycle pulse derived only from synchronized history.
module riot_edge_det #(
  parameter int PA7_SYNC = 2
) (
  input  logic CLK,
  input  logic RES,
  input  logic pin,
  input  logic pol,
  output logic match
);
  logic [PA7_SYNC-1:0] sync;
  logic                prev;
  logic                s;

  assign s = sync[PA7_SYNC-1];

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= PA7_SYNC'({sync, pin});
      prev <= s;
    end
  end

  // pol only selects which transition counts; it never feeds the history
  assign match = pol ? (s & ~prev) : (~s & prev);
endmodule

// File: rtl/riot_timer_ctrl.sv
// Bus-side controller for the interval timer: load strobes, count readback,
// timer/PA7 interrupt flags and IRQ_N generation.
module riot_timer_ctrl
  import riot_timer_ctrl_pkg::*;
#(
  parameter int PA7_SYNC = 2,
  parameter bit IRQ_REG  = 1'b1
) (
  input  logic                    CLK,
  input  logic                    RES,
  riot_timer_ctrl_if.slave        bus,
  input  logic                    PA7,
  input  logic [7:0]              TIM_OUT,
  output logic                    TIM_WE,
  output logic [1:0]              TIM_MODE,
  output logic [7:0]              TIM_IN
);
  logic       tie, pie, pol, tf, pf;
  logic [7:0] prev_cnt, dout;
  logic       irq, irq_n_q, match;
  logic       wr, rd, ld, ec, rd_cnt, rd_flg, uf;
  logic       unused_a2;

  assign unused_a2 = bus.A[2];

  assign wr     = bus.CS & ~bus.RW;
  assign rd     = bus.CS &  bus.RW;
  assign ld     = wr &  bus.A[A_TIMER_SEL];
  assign ec     = wr & ~bus.A[A_TIMER_SEL];
  assign rd_cnt = rd & ~bus.A[A_FLAG_SEL];
  assign rd_flg = rd &  bus.A[A_FLAG_SEL];

  // a load of 0xFF lands while TIM_WE is high, so it is not an underflow
  assign uf  = (prev_cnt == 8'h00) && (TIM_OUT == 8'hFF) && !TIM_WE;
  assign irq = (tf & tie) | (pf & pie);

  riot_edge_det #(.PA7_SYNC(PA7_SYNC)) u_edge (
    .CLK   (CLK),
    .RES   (RES),
    .pin   (PA7),
    .pol   (pol),
    .match (match)
  );

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      dout     <= '0;
      TIM_WE   <= 1'b0;
      TIM_MODE <= C_TIM_0001T;
      TIM_IN   <= '0;
      tie      <= 1'b0;
      pie      <= 1'b0;
      pol      <= 1'b0;
      tf       <= 1'b0;
      pf       <= 1'b0;
      prev_cnt <= '0;
      irq_n_q  <= 1'b1;
    end else begin
      TIM_WE <= ld;
      if (ld) begin
        TIM_MODE <= bus.A[1:0];
        TIM_IN   <= bus.DIN;
      end
      if (ld | rd_cnt) tie <= bus.A[A_IRQ_EN];
      if (ec) begin
        pie <= bus.A[A_PIE];
        pol <= bus.A[A_POL];
      end
      if (rd_cnt)      dout <= TIM_OUT;
      else if (rd_flg) dout <= flag_byte(tf, pf);
      // set beats clear on both flags
      tf       <= uf | (tf & ~(ld | rd_cnt));
      pf       <= match | (pf & ~rd_flg);
      prev_cnt <= TIM_OUT;
      irq_n_q  <= ~irq;
    end
  end

  assign bus.DOUT  = dout;
  assign bus.IRQ_N = IRQ_REG ? irq_n_q : ~irq;
endmodule
